// File: rtl/alu_pkg.sv
// Shared encodings for the alu issue controller: op selects, FSM states, default widths.
package alu_pkg;
    localparam int ALU_WIDTH = 64;
    localparam int ALU_TAG_W = 4;

    typedef logic [2:0] alu_op_t;

    localparam alu_op_t ALU_ADD = 3'b000;
    localparam alu_op_t ALU_SUB = 3'b001;
    localparam alu_op_t ALU_AND = 3'b010;
    localparam alu_op_t ALU_XOR = 3'b011;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Request/response channel (issuer is master) and the alu operand bus (controller is master).
interface alu_req_if #(
    parameter int WIDTH = 64,
    parameter int TAG_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] resp_z;
    logic             resp_cout;
    logic             resp_zero;
    logic             resp_neg;
    logic [TAG_W-1:0] resp_tag;

    modport master (
        output req_valid, req_op, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_z, resp_cout, resp_zero, resp_neg, resp_tag
    );
    modport slave (
        input  req_valid, req_op, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_z, resp_cout, resp_zero, resp_neg, resp_tag
    );
endinterface

interface alu_bus_if #(
    parameter int WIDTH = 64
);
    logic [WIDTH-1:0] alu_p;
    logic [WIDTH-1:0] alu_q;
    logic [2:0]       alu_sel;
    logic [WIDTH-1:0] alu_z;
    logic             alu_cout;

    modport master (output alu_p, alu_q, alu_sel, input  alu_z, alu_cout);
    modport slave  (input  alu_p, alu_q, alu_sel, output alu_z, alu_cout);
endinterface

// File: rtl/alu_tag_counter.sv
// Wrap-around sequence tag counter; advances once per accepted request.
module alu_tag_counter #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    output logic [TAG_W-1:0] o_cnt
);
    logic [TAG_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        r_cnt <= '0;
        else if (i_inc) r_cnt <= r_cnt + TAG_W'(1);
    end

    assign o_cnt = r_cnt;
endmodule

// File: rtl/alu_issue_ctrl.sv
// Drives the combinational alu from registered operands, waits one settle cycle,
// then returns the captured result with flags and tag over a valid/ready channel.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int TAG_W = ALU_TAG_W
) (
    input  logic      clk,
    input  logic      rst,
    alu_req_if.slave  req,
    alu_bus_if.master alu
);
    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_p;
    logic [WIDTH-1:0] r_q;
    logic [2:0]       r_sel;
    logic [WIDTH-1:0] r_z;
    logic             r_cout;
    logic             r_zero;
    logic             r_neg;
    logic [TAG_W-1:0] r_tag;
    logic [TAG_W-1:0] w_tag_cnt;
    logic             w_req_ready;
    logic             w_req_fire;
    logic             w_resp_fire;

    // A new request may ride the same edge that retires the pending response.
    assign w_req_ready = (r_state == IDLE) || ((r_state == RESP) && req.resp_ready);
    assign w_req_fire  = req.req_valid && w_req_ready;
    assign w_resp_fire = (r_state == RESP) && req.resp_ready;

    alu_tag_counter #(.TAG_W(TAG_W)) u_tag (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_req_fire),
        .o_cnt (w_tag_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_p     <= '0;
            r_q     <= '0;
            r_sel   <= '0;
            r_z     <= '0;
            r_cout  <= 1'b0;
            r_zero  <= 1'b0;
            r_neg   <= 1'b0;
            r_tag   <= '0;
        end else begin
            case (r_state)
                IDLE:    if (w_req_fire) r_state <= EXEC;
                EXEC:    r_state <= RESP;
                RESP: begin
                    if (w_req_fire)       r_state <= EXEC;
                    else if (w_resp_fire) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase

            if (w_req_fire) begin
                r_p   <= req.req_a;
                r_q   <= req.req_b;
                r_sel <= req.req_op;
                r_tag <= w_tag_cnt;
            end

            // alu output has settled for a full cycle by the end of EXEC.
            if (r_state == EXEC) begin
                r_z    <= alu.alu_z;
                r_cout <= alu.alu_cout;
                r_zero <= (alu.alu_z == '0);
                r_neg  <= alu.alu_z[WIDTH-1];
            end
        end
    end

    assign req.req_ready  = w_req_ready;
    assign req.resp_valid = (r_state == RESP);
    assign req.resp_z     = r_z;
    assign req.resp_cout  = r_cout;
    assign req.resp_zero  = r_zero;
    assign req.resp_neg   = r_neg;
    assign req.resp_tag   = r_tag;

    assign alu.alu_p   = r_p;
    assign alu.alu_q   = r_q;
    assign alu.alu_sel = r_sel;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Random and directed stimulus for alu_issue_ctrl against a transaction-level model.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    logic clk;
    logic rst;

    alu_req_if #(.WIDTH(64), .TAG_W(4)) rq ();
    alu_bus_if #(.WIDTH(64))            ab ();

    alu_issue_ctrl #(.WIDTH(64), .TAG_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .req (rq),
        .alu (ab)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference alu: carry is the carry out of a + b (ADD) or a + ~b + 1 (SUB).
    function automatic logic [64:0] alu_f(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        case (op)
            ALU_ADD: return {1'b0, a} + {1'b0, b};
            ALU_SUB: return {1'b0, a} + {1'b0, ~b} + 65'd1;
            ALU_AND: return {1'b0, a & b};
            ALU_XOR: return {1'b0, a ^ b};
            default: return {1'b0, a | b};
        endcase
    endfunction

    always_comb {ab.alu_cout, ab.alu_z} = alu_f(ab.alu_sel, ab.alu_p, ab.alu_q);

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Transaction model: expected responses, tag sequence, held alu operands.
    typedef struct {
        logic [63:0] z;
        logic        c;
        logic [3:0]  tag;
    } exp_t;

    exp_t        q[$];
    int          age;
    int          tagm;
    logic [63:0] hp, hq;
    logic [2:0]  hs;
    int          nresp;
    logic [63:0] last_z;
    logic        last_c, last_zero, last_neg;
    logic [3:0]  last_tag;

    always @(negedge clk) begin
        logic ev, er;
        exp_t e;
        if (rst) begin
            q.delete();
            age = 0; tagm = 0; hp = '0; hq = '0; hs = '0;
        end else begin
            if (q.size() != 0) age++;
            ev = (q.size() != 0) && (age >= 2);
            er = (q.size() == 0) || (ev && rq.resp_ready);
            chk("alu_p", ab.alu_p, hp);
            chk("alu_q", ab.alu_q, hq);
            chk("alu_sel", 64'(ab.alu_sel), 64'(hs));
            chk("resp_valid", 64'(rq.resp_valid), 64'(ev));
            chk("req_ready", 64'(rq.req_ready), 64'(er));
            if (ev) begin
                e = q[0];
                chk("resp_z", rq.resp_z, e.z);
                chk("resp_cout", 64'(rq.resp_cout), 64'(e.c));
                chk("resp_zero", 64'(rq.resp_zero), 64'(e.z == 64'd0));
                chk("resp_neg", 64'(rq.resp_neg), 64'($signed(e.z) < 0));
                chk("resp_tag", 64'(rq.resp_tag), 64'(e.tag));
                if (rq.resp_ready) begin
                    void'(q.pop_front());
                    last_z = rq.resp_z; last_c = rq.resp_cout; last_zero = rq.resp_zero;
                    last_neg = rq.resp_neg; last_tag = rq.resp_tag;
                    nresp++;
                end
            end
            if (rq.req_valid && er) begin
                logic [64:0] r;
                r = alu_f(rq.req_op, rq.req_a, rq.req_b);
                e.z = r[63:0]; e.c = r[64]; e.tag = 4'(tagm);
                q.push_back(e);
                tagm = (tagm + 1) % 16;
                hp = rq.req_a; hq = rq.req_b; hs = rq.req_op;
                age = 0;
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        int  n = 0;
        logic ok;
        rq.req_valid = 1'b1; rq.req_op = op; rq.req_a = a; rq.req_b = b;
        do begin
            @(negedge clk); ok = rq.req_ready;
            @(posedge clk); #1; n++;
        end while (!ok && n < 50);
        if (!ok) chk("accept_timeout", 64'(ok), 64'd1);
        rq.req_valid = 1'b0;
        rq.req_a = {$urandom, $urandom};
        rq.req_b = {$urandom, $urandom};
    endtask

    task automatic wait_resp();
        int n0 = nresp;
        int n = 0;
        while (nresp == n0 && n < 30) begin
            @(posedge clk); #1; n++;
        end
        if (nresp == n0) chk("resp_timeout", 64'(nresp), 64'(n0 + 1));
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!rq.resp_valid && n < 10) begin
            @(posedge clk); #1; n++;
        end
        chk("valid_seen", 64'(rq.resp_valid), 64'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1; #1;
        chk("rst_valid", 64'(rq.resp_valid), 64'd0);
        chk("rst_ready", 64'(rq.req_ready), 64'd1);
        @(posedge clk); #3 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        logic fire, pending;
        rst = 1'b1;
        rq.req_valid = 1'b0; rq.req_op = '0; rq.req_a = '0; rq.req_b = '0;
        rq.resp_ready = 1'b0;
        nresp = 0;
        #12;
        chk("reset_req_ready", 64'(rq.req_ready), 64'd1);
        chk("reset_resp_valid", 64'(rq.resp_valid), 64'd0);
        chk("reset_resp_z", rq.resp_z, 64'd0);
        chk("reset_resp_flags", {60'd0, rq.resp_cout, rq.resp_zero, rq.resp_neg, 1'b0}, 64'd0);
        chk("reset_resp_tag", 64'(rq.resp_tag), 64'd0);
        chk("reset_alu_p", ab.alu_p, 64'd0);
        @(posedge clk); #3 rst = 1'b0;
        @(posedge clk); #1;

        // Basic ADD
        rq.resp_ready = 1'b1;
        issue(ALU_ADD, 64'd5, -64'sd2);
        wait_resp();
        chk("t1_z", last_z, 64'd3);
        chk("t1_cout", 64'(last_c), 64'd1);
        chk("t1_zero_neg", {62'd0, last_zero, last_neg}, 64'd0);
        chk("t1_tag", 64'(last_tag), 64'd0);

        // SUB held under backpressure, then negative result
        rq.resp_ready = 1'b0;
        issue(ALU_SUB, 64'd3, 64'd2);
        wait_valid();
        repeat (5) begin @(posedge clk); #1; end
        chk("t2_hold_z", rq.resp_z, 64'd1);
        chk("t2_hold_ready", 64'(rq.req_ready), 64'd0);
        rq.resp_ready = 1'b1;
        wait_resp();
        chk("t2_z", last_z, 64'd1);
        issue(ALU_SUB, -64'sd3, 64'd2);
        wait_resp();
        chk("t2_neg_z", last_z, -64'sd5);
        chk("t2_neg", 64'(last_neg), 64'd1);

        // Back-to-back with tags restarting from reset
        do_reset();
        rq.resp_ready = 1'b1;
        issue(ALU_AND, 64'd3, 64'd2);
        issue(ALU_XOR, 64'd2, 64'd2);
        chk("t3_first_z", last_z, 64'd2);
        chk("t3_first_tag", 64'(last_tag), 64'd0);
        wait_resp();
        chk("t3_second_zero", 64'(last_zero), 64'd1);
        chk("t3_second_tag", 64'(last_tag), 64'd1);

        // Tag wrap over 17 requests
        do_reset();
        for (int i = 0; i < 17; i++) begin
            issue(3'($urandom_range(0, 7)), {$urandom, $urandom}, {$urandom, $urandom});
            wait_resp();
            chk("t4_tag", 64'(last_tag), 64'(i % 16));
        end

        // Operand hold while req_a changes in EXEC
        issue(ALU_ADD, 64'd100, 64'd23);
        chk("t6_alu_p", ab.alu_p, 64'd100);
        wait_resp();
        chk("t6_z", last_z, 64'd123);

        // Asynchronous reset during EXEC
        issue(ALU_ADD, 64'd1, 64'd1);
        #3 rst = 1'b1; #1;
        chk("t5_exec_valid", 64'(rq.resp_valid), 64'd0);
        chk("t5_exec_ready", 64'(rq.req_ready), 64'd1);
        @(posedge clk); #3 rst = 1'b0;
        @(posedge clk); #1;
        issue(ALU_XOR, 64'd7, 64'd1);
        wait_resp();
        chk("t5_exec_tag", 64'(last_tag), 64'd0);

        // Asynchronous reset during RESP
        rq.resp_ready = 1'b0;
        issue(ALU_AND, 64'hff, 64'h0f);
        wait_valid();
        #2 rst = 1'b1; #1;
        chk("t5_resp_valid", 64'(rq.resp_valid), 64'd0);
        chk("t5_resp_ready", 64'(rq.req_ready), 64'd1);
        @(posedge clk); #3 rst = 1'b0;
        @(posedge clk); #1;
        rq.resp_ready = 1'b1;
        issue(ALU_ADD, 64'd2, 64'd2);
        wait_resp();
        chk("t5_resp_tag", 64'(last_tag), 64'd0);

        // Random traffic with random backpressure
        pending = 1'b0;
        repeat (400) begin
            @(negedge clk); fire = rq.req_valid && rq.req_ready;
            @(posedge clk); #1;
            if (fire) begin
                pending = 1'b0;
                rq.req_valid = 1'b0;
                rq.req_a = {$urandom, $urandom};
            end
            if (!pending && $urandom_range(0, 2) != 0) begin
                rq.req_op = 3'($urandom_range(0, 7));
                rq.req_a  = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 4)) : {$urandom, $urandom};
                rq.req_b  = ($urandom_range(0, 3) == 0) ? rq.req_a : {$urandom, $urandom};
                rq.req_valid = 1'b1;
                pending = 1'b1;
            end
            rq.resp_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk); fire = rq.req_valid && rq.req_ready;
        @(posedge clk); #1;
        if (!fire) begin
            rq.req_valid = 1'b1;
            issue(rq.req_op, rq.req_a, rq.req_b);
        end
        rq.req_valid = 1'b0;
        rq.resp_ready = 1'b1;
        repeat (6) begin @(posedge clk); #1; end
        chk("drain_empty", 64'(q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
